// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: tracks EX/MEM/WB destination registers and
// drives stall, bubble, flush and freeze enables plus forwarding selects.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_stall_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             pipe_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             rf_byp_a,
  output logic             rf_byp_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_STALL,
    MODE_FLUSH,
    MODE_FREEZE
  } mode_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
  } sb_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The load flag only matters while the producer sits in EX, so it is kept there alone.
  sb_t              ex_q, mem_q, wb_q, ex_d, mem_d, wb_d;
  logic             ex_mr_q, ex_mr_d;
  logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0] stall_q, flush_q, stall_d, flush_d;
  logic             lu;
  mode_e            mode;

  function automatic logic sb_match(input sb_t e, input logic [4:0] r);
    return e.v & e.rw & (e.rd == r) & (e.rd != 5'd31);
  endfunction

  function automatic logic [1:0] fwd_next(input logic uses, input logic [4:0] r,
                                          input sb_t ex_e, input sb_t mem_e);
    if (uses & sb_match(ex_e, r))       return 2'b10;
    else if (uses & sb_match(mem_e, r)) return 2'b01;
    else                                return 2'b00;
  endfunction

  assign lu = id_valid & ex_q.v & ex_mr_q & (ex_q.rd != 5'd31) &
              ((id_uses_rn & (id_rn == ex_q.rd)) | (id_uses_rm & (id_rm == ex_q.rd)));

  assign rf_byp_a = id_uses_rn & sb_match(wb_q, id_rn);
  assign rf_byp_b = id_uses_rm & sb_match(wb_q, id_rm);

  always_comb begin
    mode = MODE_RUN;
    if (mem_stall_req)        mode = MODE_FREEZE;
    else if (ex_branch_taken) mode = MODE_FLUSH;
    else if (lu)              mode = MODE_STALL;
  end

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    pipe_we      = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_d         = ex_q;
    ex_mr_d      = ex_mr_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    fwd_a_d      = fwd_a_q;
    fwd_b_d      = fwd_b_q;
    stall_d      = stall_q;
    flush_d      = flush_q;

    case (mode)
      MODE_FREEZE: begin
        pc_we    = 1'b0;
        if_id_we = 1'b0;
        pipe_we  = 1'b0;
      end
      MODE_FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        wb_d         = mem_q;
        mem_d        = ex_q;
        ex_d         = '0;
        ex_mr_d      = 1'b0;
        fwd_a_d      = 2'b00;
        fwd_b_d      = 2'b00;
        flush_d      = (flush_q == CNT_MAX) ? flush_q : flush_q + CNT_ONE;
      end
      MODE_STALL: begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_bubble = 1'b1;
        wb_d         = mem_q;
        mem_d        = ex_q;
        ex_d         = '0;
        ex_mr_d      = 1'b0;
        fwd_a_d      = 2'b00;
        fwd_b_d      = 2'b00;
        stall_d      = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_ONE;
      end
      default: begin
        wb_d    = mem_q;
        mem_d   = ex_q;
        ex_d    = '{v: id_valid, rd: id_rd, rw: id_regwrite};
        ex_mr_d = id_memread;
        fwd_a_d = fwd_next(id_uses_rn, id_rn, ex_q, mem_q);
        fwd_b_d = fwd_next(id_uses_rm, id_rm, ex_q, mem_q);
      end
    endcase

    // Hold the whole pipe still and squash ID/EX while reset is asserted.
    if (!rst_n) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      pipe_we      = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      ex_mr_q <= 1'b0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      ex_q    <= ex_d;
      ex_mr_q <= ex_mr_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
